// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX training and statistics signals of the branch predictor
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic [31:0] update_count;
  logic [31:0] mispredict_count;
  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target, ex_mispredict,
    input  predict_taken, predict_target, update_count, mispredict_count
  );
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target, ex_mispredict,
    output predict_taken, predict_target, update_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and update/mispredict statistics
module branch_predictor #(
  parameter int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - INDEX_W
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bp
);
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [31:0]        upd_cnt_q, mis_cnt_q;
  logic [INDEX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               l_hit, u_hit;
  logic [1:0]         ctr_d, u_ctr;
  logic               unused;
  assign unused = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};
  assign l_idx = bp.if_pc[INDEX_W+1:2];
  assign l_tag = bp.if_pc[31:INDEX_W+2];
  assign u_idx = bp.ex_pc[INDEX_W+1:2];
  assign u_tag = bp.ex_pc[31:INDEX_W+2];
  assign l_hit = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign u_ctr = ctr_q[u_idx];
  assign bp.predict_taken = l_hit && ctr_q[l_idx][1];
  assign bp.predict_target = bp.predict_taken ? tgt_q[l_idx] : bp.if_pc + 32'd4;
  assign bp.update_count = upd_cnt_q;
  assign bp.mispredict_count = mis_cnt_q;
  always_comb begin
    ctr_d = bp.ex_is_jump ? 2'b11
          : bp.ex_taken   ? (u_ctr == 2'b11 ? 2'b11 : u_ctr + 2'd1)
          :                 (u_ctr == 2'b00 ? 2'b00 : u_ctr - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else if (bp.ex_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_d;
        if (bp.ex_is_jump || bp.ex_taken) tgt_q[u_idx] <= bp.ex_target;
      end else if (bp.ex_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= bp.ex_target;
        ctr_q[u_idx]   <= bp.ex_is_jump ? 2'b11 : 2'b10;
      end
      upd_cnt_q <= upd_cnt_q + {31'd0, ~&upd_cnt_q};
      mis_cnt_q <= mis_cnt_q + {31'd0, bp.ex_mispredict && ~&mis_cnt_q};
    end
  end
endmodule
